// File: rtl/serdes_pkg.sv
// serdes_pkg: shared FSM state types, line constants and frame-length helper for serdes_framed.
// Parity states and the longer frame exist only when SERDES_PARITY_EN is defined.
package serdes_pkg;
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef SERDES_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
`ifdef SERDES_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  function automatic int frame_len(input int data_w);
`ifdef SERDES_PARITY_EN
    return data_w + 3;
`else
    return data_w + 2;
`endif
  endfunction
endpackage

// File: rtl/serdes_rx_deframer.sv
// serdes_rx_deframer: RX FSM sampling one line bit per enabled clk; delivers words with parity/frame flags.
// Parity capture and checking exist only with SERDES_PARITY_EN.
module serdes_rx_deframer import serdes_pkg::*; #(
  parameter int DATA_W = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sample,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              par_err,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W);
  rx_state_t state, state_n;
  logic [DATA_W-1:0] sh, sh_n, sh_in, data_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pulse, pulse_n, ferr_n, last;
  assign sh_in = LSB_FIRST ? {sample, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], sample};
  assign last = cnt == CW'(DATA_W - 1);
  assign valid = pulse & en;
`ifdef SERDES_PARITY_EN
  logic par, par_n, perr, perr_n;
  assign par_err = perr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      par <= 1'b0;
      perr <= 1'b0;
    end else if (en) begin
      par <= par_n;
      perr <= perr_n;
    end
`else
  assign par_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    sh_n = sh;
    cnt_n = cnt;
    data_n = data;
    pulse_n = 1'b0;
    ferr_n = frame_err;
`ifdef SERDES_PARITY_EN
    par_n = par;
    perr_n = perr;
`endif
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (sample == START_BIT) state_n = RX_DATA;
      end
      RX_DATA: begin
        sh_n = sh_in;
        cnt_n = cnt + 1'b1;
`ifdef SERDES_PARITY_EN
        if (last) state_n = RX_PAR;
`else
        if (last) state_n = RX_STOP;
`endif
      end
`ifdef SERDES_PARITY_EN
      RX_PAR: begin
        par_n = sample;
        state_n = RX_STOP;
      end
`endif
      RX_STOP: begin
        data_n = sh;
        pulse_n = 1'b1;
        ferr_n = sample != LINE_IDLE;
`ifdef SERDES_PARITY_EN
        perr_n = ^sh ^ par;
`endif
        state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RX_IDLE;
      sh <= '0;
      cnt <= '0;
      data <= '0;
      pulse <= 1'b0;
      frame_err <= 1'b0;
    end else if (en) begin
      state <= state_n;
      sh <= sh_n;
      cnt <= cnt_n;
      data <= data_n;
      pulse <= pulse_n;
      frame_err <= ferr_n;
    end
endmodule

// File: rtl/serdes_framed.sv
// serdes_framed: framed SERDES top holding the TX FSM and loopback mux; RX lives in serdes_rx_deframer.
// Define SERDES_PARITY_EN to add an even-parity bit to every frame.
module serdes_framed import serdes_pkg::*; #(
  parameter int DATA_W = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              loopback,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  input  logic              ser_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_par_err,
  output logic              rx_frame_err
);
  localparam int CW = $clog2(DATA_W);
  tx_state_t state, state_n;
  logic [DATA_W-1:0] sh, sh_n, sh_adv;
  logic [CW-1:0] cnt, cnt_n;
  logic ser_n, head, last, accept, rx_line;
  assign head = LSB_FIRST ? sh[0] : sh[DATA_W-1];
  assign sh_adv = LSB_FIRST ? sh >> 1 : sh << 1;
  assign last = cnt == CW'(DATA_W - 1);
  assign tx_ready = en && (state == TX_IDLE || state == TX_STOP);
  assign accept = tx_valid && tx_ready;
  assign rx_line = loopback ? ser_out : ser_in;
`ifdef SERDES_PARITY_EN
  logic par, par_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par <= 1'b0;
    else if (en) par <= par_n;
`endif
  always_comb begin
    state_n = state;
    sh_n = sh;
    cnt_n = cnt;
    ser_n = ser_out;
`ifdef SERDES_PARITY_EN
    par_n = par;
`endif
    case (state)
      TX_IDLE, TX_STOP: begin
        state_n = TX_IDLE;
        ser_n = LINE_IDLE;
        if (accept) begin
          state_n = TX_START;
          sh_n = tx_data;
          ser_n = START_BIT;
`ifdef SERDES_PARITY_EN
          par_n = ^tx_data;
`endif
        end
      end
      TX_START: begin
        state_n = TX_DATA;
        ser_n = head;
        sh_n = sh_adv;
        cnt_n = '0;
      end
      TX_DATA: begin
        if (last) begin
`ifdef SERDES_PARITY_EN
          state_n = TX_PAR;
          ser_n = par;
`else
          state_n = TX_STOP;
          ser_n = LINE_IDLE;
`endif
        end else begin
          ser_n = head;
          sh_n = sh_adv;
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef SERDES_PARITY_EN
      TX_PAR: begin
        state_n = TX_STOP;
        ser_n = LINE_IDLE;
      end
`endif
      default: state_n = TX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= TX_IDLE;
      sh <= '0;
      cnt <= '0;
      ser_out <= LINE_IDLE;
    end else if (en) begin
      state <= state_n;
      sh <= sh_n;
      cnt <= cnt_n;
      ser_out <= ser_n;
    end
  serdes_rx_deframer #(.DATA_W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sample    (rx_line),
    .data      (rx_data),
    .valid     (rx_valid),
    .par_err   (rx_par_err),
    .frame_err (rx_frame_err)
  );
endmodule

// File: tb/tb_serdes_framed.sv
// tb_serdes_framed: directed + random checks of serdes_framed against a frame-level line model.
// Covers 8-bit LSB-first and 16-bit MSB-first instances; honours SERDES_PARITY_EN.
module tb_serdes_framed;
`ifdef SERDES_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = 8 + 2 + P;
  localparam int F16 = 16 + 2 + P;
  logic clk = 1'b0;
  logic rst_n, en, loopback, tx_valid, ser_in;
  logic [7:0] tx_data;
  logic tx_ready, ser_out, rx_valid, rx_par_err, rx_frame_err;
  logic [7:0] rx_data;
  logic tx_valid16;
  logic [15:0] tx_data16, rx_data16;
  logic tx_ready16, ser_out16, rx_valid16, rx_par_err16, rx_frame_err16;
  logic [7:0] words [8];
  int checks = 0, passes = 0, fails = 0;
  always #5 clk = ~clk;
  serdes_framed #(.DATA_W(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .loopback(loopback),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ser_out(ser_out), .ser_in(ser_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_par_err(rx_par_err), .rx_frame_err(rx_frame_err)
  );
  serdes_framed #(.DATA_W(16), .LSB_FIRST(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .loopback(1'b1),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .ser_out(ser_out16), .ser_in(1'b1), .rx_data(rx_data16), .rx_valid(rx_valid16),
    .rx_par_err(rx_par_err16), .rx_frame_err(rx_frame_err16)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // Line bit j of a frame: start, data in wire order, optional even parity (possibly flipped), stop.
  function automatic logic [63:0] frame_bits(input logic [31:0] d, input int w, input bit lsb,
                                             input bit flip, input bit stop);
    logic [63:0] f;
    bit p;
    int j;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < w; i++) begin
      f[1 + i] = lsb ? d[i] : d[w - 1 - i];
      p ^= d[i];
    end
    j = w + 1;
    if (P == 1) begin
      f[j] = p ^ flip;
      j++;
    end
    f[j] = stop;
    return f;
  endfunction
  // Loopback stream of n words with tx_valid held: checks line, ready and RX every cycle.
  task automatic run_stream(input int n);
    logic [63:0] f [8];
    int i, b;
    for (int w = 0; w < n; w++) f[w] = frame_bits(32'(words[w]), 8, 1'b1, 1'b0, 1'b1);
    loopback = 1'b1;
    tx_valid = 1'b1;
    tx_data = words[0];
    for (int c = 1; c <= n * F + 2; c++) begin
      @(negedge clk);
      i = (c - 1) / F;
      b = (c - 1) % F;
      if (b == 0) begin
        tx_valid = i + 1 < n;
        if (i + 1 < n) tx_data = words[i + 1];
      end
      check("ser_out", 32'(ser_out), 32'(i < n ? f[i][b] : 1'b1));
      check("tx_ready", 32'(tx_ready), 32'(i >= n || b == F - 1));
      check("rx_valid", 32'(rx_valid), 32'(b == 0 && i >= 1 && i <= n));
      if (b == 0 && i >= 1 && i <= n) begin
        check("rx_data", 32'(rx_data), 32'(words[i - 1]));
        check("rx_par_err", 32'(rx_par_err), 32'(0));
        check("rx_frame_err", 32'(rx_frame_err), 32'(0));
      end
    end
  endtask
  // Externally driven frame on ser_in, optionally with bad parity or a zero stop bit.
  task automatic ext_frame(input logic [7:0] d, input bit flip, input bit stop);
    logic [63:0] f;
    f = frame_bits(32'(d), 8, 1'b1, flip, stop);
    loopback = 1'b0;
    for (int j = 0; j < F; j++) begin
      ser_in = f[j];
      @(negedge clk);
      check("ext_rx_valid", 32'(rx_valid), 32'(j == F - 1));
    end
    check("ext_rx_data", 32'(rx_data), 32'(d));
    check("ext_par_err", 32'(rx_par_err), 32'(P == 1 && flip));
    check("ext_frame_err", 32'(rx_frame_err), 32'(!stop));
    ser_in = 1'b1;
    @(negedge clk);
    check("ext_rx_valid_after", 32'(rx_valid), 32'(0));
    loopback = 1'b1;
  endtask
  task automatic run16(input logic [15:0] d);
    logic [63:0] f;
    f = frame_bits(32'(d), 16, 1'b0, 1'b0, 1'b1);
    tx_valid16 = 1'b1;
    tx_data16 = d;
    for (int c = 1; c <= F16 + 2; c++) begin
      @(negedge clk);
      tx_valid16 = 1'b0;
      check("ser_out16", 32'(ser_out16), 32'(c <= F16 ? f[c - 1] : 1'b1));
      check("rx_valid16", 32'(rx_valid16), 32'(c == F16 + 1));
      if (c == F16 + 1) begin
        check("rx_data16", 32'(rx_data16), 32'(d));
        check("rx_par_err16", 32'(rx_par_err16), 32'(0));
        check("rx_frame_err16", 32'(rx_frame_err16), 32'(0));
      end
    end
  endtask
  // en low for 5 edges starting mid-DATA: everything freezes, frame stretches by 5 cycles.
  task automatic en_stall(input logic [7:0] d);
    logic [63:0] f;
    int e;
    f = frame_bits(32'(d), 8, 1'b1, 1'b0, 1'b1);
    tx_valid = 1'b1;
    tx_data = d;
    for (int c = 1; c <= F + 8; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (c == 4) en = 1'b0;
      if (c == 9) en = 1'b1;
      #1;
      e = c <= 4 ? c : (c <= 9 ? 4 : c - 5);
      check("stall_ser_out", 32'(ser_out), 32'(e <= F ? f[e - 1] : 1'b1));
      check("stall_tx_ready", 32'(tx_ready), 32'(en && e >= F));
      check("stall_rx_valid", 32'(rx_valid), 32'(en && e == F + 1));
      if (e == F + 1) check("stall_rx_data", 32'(rx_data), 32'(d));
    end
  endtask
  initial begin
    int n;
    rst_n = 1'b1;
    en = 1'b1;
    loopback = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    ser_in = 1'b1;
    tx_valid16 = 1'b0;
    tx_data16 = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ser_out", 32'(ser_out), 32'(1));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_rx_data", 32'(rx_data), 32'(0));
    check("rst_par_err", 32'(rx_par_err), 32'(0));
    check("rst_frame_err", 32'(rx_frame_err), 32'(0));
    check("rst_rx_valid16", 32'(rx_valid16), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    words[0] = 8'hA5;
    run_stream(1);
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h3C;
    run_stream(3);
    ext_frame(8'h81, 1'b1, 1'b1);
    ext_frame(8'h81, 1'b0, 1'b0);
    ext_frame(8'h81, 1'b0, 1'b1);
    run16(16'h8001);
    @(negedge clk);
    en = 1'b0;
    #1;
    check("en_low_tx_ready", 32'(tx_ready), 32'(0));
    check("en_low_ser_out", 32'(ser_out), 32'(1));
    en = 1'b1;
    en_stall(8'hC3);
    tx_valid = 1'b1;
    tx_data = 8'h07;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    check("pre_rst_data_bit3", 32'(ser_out), 32'(0));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ser_out", 32'(ser_out), 32'(1));
    check("mid_rst_tx_ready", 32'(tx_ready), 32'(1));
    check("mid_rst_rx_valid", 32'(rx_valid), 32'(0));
    check("mid_rst_rx_data", 32'(rx_data), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    words[0] = 8'h5A;
    run_stream(1);
    for (int t = 0; t < 6; t++) begin
      n = 1 + int'($urandom_range(0, 3));
      for (int w = 0; w < n; w++) words[w] = 8'($urandom);
      run_stream(n);
      ext_frame(8'($urandom), 1'($urandom), 1'($urandom));
    end
    run16(16'($urandom));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
